seg_scan_mux: RTL and testbench

- Parametrised time-multiplexed seven-segment scanner for the display path.
- Replaces the fixed 4-digit nibble selector.
- Latches a DIGITS-wide hex word, rotates one active digit every SCAN_DIV clocks, inserts anti-ghosting dead time, and drives active-low anodes and segments directly to the board.

---
 rtl/seg_scan_mux.sv | 153 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: snapshots a hex word and drives active-low anodes/segments.
// Optional per-digit blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_mux #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int CNT_W        = 16
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_in,
`endif
  input  logic                  load,
  output logic [DIGITS-1:0]     an_out,
  output logic [7:0]            seg_out,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

  // Segment bits {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  logic [4*DIGITS-1:0] hex_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic [CNT_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic                slot_end;
  logic                frame_end;
  logic                blink_off;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   an_next;
  logic [7:0]          seg_next;

  assign slot_end  = (presc == LAST_CNT);
  assign frame_end = slot_end && (idx == LAST_IDX);
  assign nibble    = hex_q[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (load) begin
      hex_q   <= hex_in;
      dp_q    <= dp_in;
      blank_q <= blank_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGITS-1:0] blink_q;
  logic [FR_W-1:0]   frame_cnt;
  logic              blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
    end else if (load) begin
      blink_q <= blink_in;
    end
  end

  // Phase flips after every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase && blink_q[idx];
`else
  assign blink_off = 1'b0;
`endif

  // Guard window keeps every anode off so the previous digit cannot ghost.
  always_comb begin
    an_next  = '1;
    seg_next = 8'hFF;
    if (presc >= GUARD_CNT) begin
      an_next = ~(DIGITS'(1) << idx);
      if (!blank_q[idx] && !blink_off) begin
        seg_next = {~dp_q[idx], decode(nibble)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out     <= '1;
      seg_out    <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an_out     <= an_next;
      seg_out    <= seg_next;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a cycle-count reference model predicts each registered output.
// Blink stays disabled here (blink_in tied low when SEG_SCAN_BLINK_EN is defined).
module tb_seg_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hex_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blink_in = '0;
`endif
  logic [3:0]  an_out;
  logic [7:0]  seg_out;
  logic        frame_tick;

  seg_scan_mux #(
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .GUARD(GUARD),
    .CNT_W(CNT_W)
`ifdef SEG_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .hex_in(hex_in),
    .dp_in(dp_in),
    .blank_in(blank_in),
`ifdef SEG_SCAN_BLINK_EN
    .blink_in(blink_in),
`endif
    .load(load),
    .an_out(an_out),
    .seg_out(seg_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int test_count = 0;
  int fail_count = 0;

  logic [7:0] seg_table [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [15:0] m_hex;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected output after the k-th clock edge since reset release, from slot arithmetic.
  function automatic exp_t model_out(input int k);
    exp_t e;
    int   p;
    int   d;
    p = k % SCAN_DIV;
    d = (k / SCAN_DIV) % DIGITS;
    e.an   = 4'hF;
    e.seg  = 8'hFF;
    e.tick = (p == SCAN_DIV - 1) && (d == DIGITS - 1);
    if (p >= GUARD) begin
      e.an = 4'hF ^ (4'd1 << d);
      if (!m_blank[d]) begin
        e.seg = seg_table[m_hex[4*d +: 4]];
        if (m_dp[d]) e.seg = e.seg & 8'h7F;
      end
    end
    return e;
  endfunction

  initial begin
    int k = 0;
    m_hex = '0;
    m_dp = '0;
    m_blank = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_hex = '0;
        m_dp = '0;
        m_blank = '0;
        k = 0;
        exp_q.delete();
      end else begin
        exp_q.push_back(model_out(k));
        k++;
        if (load) begin
          m_hex = hex_in;
          m_dp = dp_in;
          m_blank = blank_in;
        end
      end
    end
  end

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("an_out", {12'd0, an_out}, {12'd0, e.an});
        checkOutput("seg_out", {8'd0, seg_out}, {8'd0, e.seg});
        checkOutput("frame_tick", {15'd0, frame_tick}, {15'd0, e.tick});
        checkOutput("onehot_low", {15'd0, ($countones(~an_out) <= 1)}, 16'd1);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    hex_in = h;
    dp_in = d;
    blank_in = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    runCycles(2);
    checkOutput("reset_an", {12'd0, an_out}, 16'h000F);
    checkOutput("reset_seg", {8'd0, seg_out}, 16'h00FF);
    checkOutput("reset_tick", {15'd0, frame_tick}, 16'd0);
    rst = 1'b0;

    applyStimulus(16'h3210, 4'b0000, 4'b0000);
    runCycles(64);

    applyStimulus(16'hFEDC, 4'b0000, 4'b0000);
    runCycles(32);
    applyStimulus(16'hBA98, 4'b0000, 4'b0000);
    runCycles(32);
    applyStimulus(16'h7654, 4'b0000, 4'b0000);
    runCycles(32);
    applyStimulus(16'h3210, 4'b0000, 4'b0000);
    runCycles(32);

    applyStimulus(16'h8888, 4'b0101, 4'b0010);
    runCycles(32);

    // Inputs change without load: display must keep the old snapshot.
    @(negedge clk);
    hex_in = 16'hABCD;
    dp_in = 4'b1111;
    runCycles(32);
    runCycles(11);
    applyStimulus(16'h5A5A, 4'b0000, 4'b1000);
    runCycles(40);

    // Asynchronous reset in the middle of a lit slot.
    runCycles(4);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_an", {12'd0, an_out}, 16'h000F);
    checkOutput("async_rst_seg", {8'd0, seg_out}, 16'h00FF);
    checkOutput("async_rst_tick", {15'd0, frame_tick}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    runCycles(40);

    repeat (400) begin
      @(negedge clk);
      hex_in = 16'($urandom);
      dp_in = 4'($urandom);
      blank_in = 4'($urandom);
      load = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    load = 1'b0;
    runCycles(40);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
